// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared state codes, reset constants and PC alignment helper for the fetch stage.
package fetch_unit_pkg;
  typedef enum logic [1:0] {FETCH = 2'd0, DRAIN = 2'd1, HOLD = 2'd2} fetch_state_e;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSN_DEF = 32'h0000_0013;
  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage owning the PC, imem handshake, IF/ID register and one-entry stall buffer.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSN = NOP_INSN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc4,
  output logic [31:0] if_pc,
  output logic [31:0] if_ir,
  output logic        if_valid
);
  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, tgt_q, tgt_d, hpc_q, hpc_d, hir_q, hir_d;
  logic [31:0] if_pc_q, if_pc_d, if_ir_q, if_ir_d;
  logic        if_valid_q, if_valid_d, ack;
  assign imem_req  = !rst && state_q != HOLD;
  assign imem_addr = pc_q;
  assign pc4       = pc_q + 32'd4;
  assign if_pc     = if_pc_q;
  assign if_ir     = if_ir_q;
  assign if_valid  = if_valid_q;
  assign ack       = imem_ack && state_q != HOLD;
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    hpc_d      = hpc_q;
    hir_d      = hir_q;
    if_pc_d    = if_pc_q;
    if_ir_d    = if_ir_q;
    if_valid_d = if_valid_q;
    if (redirect) begin
      if_valid_d = 1'b0;
      // an unacked request must keep its address, so the target waits in tgt_q
      if (state_q == FETCH && !ack) begin
        tgt_d   = align(next_pc);
        state_d = DRAIN;
      end else if (state_q == DRAIN && !ack) begin
        tgt_d = align(next_pc);
      end else begin
        pc_d    = align(next_pc);
        state_d = FETCH;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (ack) begin
            pc_d = align(next_pc);
            if (stall) begin
              hpc_d   = pc_q;
              hir_d   = imem_rdata;
              state_d = HOLD;
            end else begin
              if_pc_d    = pc_q;
              if_ir_d    = imem_rdata;
              if_valid_d = 1'b1;
            end
          end else if (!stall) begin
            if_valid_d = 1'b0;
          end
        end
        DRAIN: begin
          if (!stall) if_valid_d = 1'b0;
          if (ack) begin
            pc_d    = tgt_q;
            state_d = FETCH;
          end
        end
        default: begin
          if (!stall) begin
            if_pc_d    = hpc_q;
            if_ir_d    = hir_q;
            if_valid_d = 1'b1;
            state_d    = FETCH;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= align(RESET_PC);
      tgt_q      <= '0;
      hpc_q      <= '0;
      hir_q      <= NOP_INSN;
      if_pc_q    <= '0;
      if_ir_q    <= NOP_INSN;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      hpc_q      <= hpc_d;
      hir_q      <= hir_d;
      if_pc_q    <= if_pc_d;
      if_ir_q    <= if_ir_d;
      if_valid_q <= if_valid_d;
    end
  end
endmodule
